// File: rtl/rle_enc.sv
// Run-length encoder for the compacted sample stream: value words followed by
// count words whose flag bit sits at the MSB of the active sample width.
module rle_enc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  disabledGroups,
    input  logic        rle_enable,
    input  logic        rle_flush,
    input  logic        sti_valid,
    input  logic [31:0] sti_data,
    output logic        sto_valid,
    output logic [31:0] sto_data
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state, state_n;
    logic [30:0] last, last_n;
    logic [30:0] count, count_n;
    logic        pend_vld, pend_vld_n;
    logic [30:0] pend_val, pend_val_n;
    logic        flush_req, flush_n;
    logic [1:0]  w_sel, w_nxt;

    logic [2:0]  n_en;
    logic [30:0] val_mask;
    logic [31:0] flag;
    logic [30:0] v;
    logic [31:0] cw_cnt, cw_max;
    logic        emit;
    logic [31:0] word;

    // width select: 0=8, 1=16, 2=24, 3=32 bits
    always_comb begin
        n_en = 3'(!disabledGroups[0]) + 3'(!disabledGroups[1])
             + 3'(!disabledGroups[2]) + 3'(!disabledGroups[3]);
        case (n_en)
            3'd1:    w_nxt = 2'd0;
            3'd2:    w_nxt = 2'd1;
            3'd3:    w_nxt = 2'd2;
            default: w_nxt = 2'd3;
        endcase
    end

    always_comb begin
        case (w_sel)
            2'd0:    val_mask = 31'h0000_007F;
            2'd1:    val_mask = 31'h0000_7FFF;
            2'd2:    val_mask = 31'h007F_FFFF;
            default: val_mask = 31'h7FFF_FFFF;
        endcase
        flag   = {1'b0, val_mask} + 32'd1;
        v      = sti_data[30:0] & val_mask;
        cw_cnt = flag | {1'b0, count};
        cw_max = flag | {1'b0, val_mask};
    end

    always_comb begin
        state_n    = state;
        last_n     = last;
        count_n    = count;
        pend_vld_n = pend_vld;
        pend_val_n = pend_val;
        flush_n    = flush_req | rle_flush;
        emit       = 1'b0;
        word       = '0;
        if (sti_valid) begin
            if (state == IDLE || (v != last && count == '0)) begin
                // queue v: a full pending slot drains first, v takes its place
                emit = 1'b1;
                if (pend_vld) begin
                    word       = {1'b0, pend_val};
                    pend_val_n = v;
                end else begin
                    word = {1'b0, v};
                end
                last_n  = v;
                count_n = '0;
                state_n = RUN;
            end else if (v == last) begin
                if (count == val_mask) begin
                    emit    = 1'b1;
                    word    = cw_max;
                    count_n = 31'd1;
                end else begin
                    count_n = count + 31'd1;
                    if (pend_vld) begin
                        emit       = 1'b1;
                        word       = {1'b0, pend_val};
                        pend_vld_n = 1'b0;
                    end
                end
            end else begin
                // run ends on a new value: count goes out now, value waits a cycle
                emit       = 1'b1;
                word       = cw_cnt;
                pend_vld_n = 1'b1;
                pend_val_n = v;
                last_n     = v;
                count_n    = '0;
            end
        end else if (pend_vld) begin
            emit       = 1'b1;
            word       = {1'b0, pend_val};
            pend_vld_n = 1'b0;
        end else if (flush_req || rle_flush) begin
            if (count != '0) begin
                emit = 1'b1;
                word = cw_cnt;
            end
            state_n = IDLE;
            count_n = '0;
            flush_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sto_valid <= 1'b0;
            sto_data  <= '0;
            state     <= IDLE;
            last      <= '0;
            count     <= '0;
            pend_vld  <= 1'b0;
            pend_val  <= '0;
            flush_req <= 1'b0;
            w_sel     <= 2'd3;
        end else if (!rle_enable) begin
            sto_valid <= sti_valid;
            sto_data  <= sti_data;
            state     <= IDLE;
            count     <= '0;
            pend_vld  <= 1'b0;
            flush_req <= 1'b0;
            w_sel     <= w_nxt;
        end else begin
            sto_valid <= emit;
            if (emit) sto_data <= word;
            state     <= state_n;
            last      <= last_n;
            count     <= count_n;
            pend_vld  <= pend_vld_n;
            pend_val  <= pend_val_n;
            flush_req <= flush_n;
        end
    end

endmodule

// File: tb/tb_rle_enc.sv
// Bench for rle_enc: directed scenarios plus randomized streams checked
// against a run-grouping reference model.
module tb_rle_enc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  disabledGroups = 4'b0000;
    logic        rle_enable = 1'b0;
    logic        rle_flush = 1'b0;
    logic        sti_valid = 1'b0;
    logic [31:0] sti_data = '0;
    logic        sto_valid;
    logic [31:0] sto_data;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    rle_enc dut (
        .clk(clk), .rst_n(rst_n), .disabledGroups(disabledGroups),
        .rle_enable(rle_enable), .rle_flush(rle_flush),
        .sti_valid(sti_valid), .sti_data(sti_data),
        .sto_valid(sto_valid), .sto_data(sto_data)
    );

    // one clock of stimulus; outputs sampled 1 time unit after the edge
    task automatic cyc(input logic v, input logic [31:0] d, input logic f);
        sti_valid = v; sti_data = d; rle_flush = f;
        @(posedge clk); #1;
        sti_valid = 1'b0; rle_flush = 1'b0;
        if (rst_n && rle_enable) begin
            n_checks++;
            assert (!(dut.count != 0 && dut.pend_vld)) else begin
                n_fails++;
                $display("FAIL invariant: count=%0d with pending set, required pending empty", dut.count);
            end
        end
    endtask

    task automatic set_mode(input logic [3:0] dg);
        rle_enable = 1'b0;
        disabledGroups = dg;
        cyc(1'b0, 32'h0, 1'b0);
        rle_enable = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (sto_valid !== 1'b0 || sto_data !== 32'h0) begin
            n_fails++;
            $display("FAIL reset: got v=%b d=%h, expected v=0 d=00000000", sto_valid, sto_data);
        end
        @(negedge clk); rst_n = 1'b1;
        // reset width is 32 bits: only bit 31 is stripped
        rle_enable = 1'b1;
        cyc(1'b1, 32'hC000_0001, 1'b0);
        n_checks++;
        if (sto_valid !== 1'b1 || sto_data !== 32'h4000_0001) begin
            n_fails++;
            $display("FAIL reset_width: got v=%b d=%h, expected v=1 d=40000001", sto_valid, sto_data);
        end
        cyc(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (sto_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_flush: got v=%b, expected v=0", sto_valid);
        end
    endtask

    task automatic test_passthrough;
        logic [31:0] d [2] = '{32'hDEAD_BEEF, 32'h1234_5678};
        rle_enable = 1'b0;
        disabledGroups = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, d[i], 1'b0);
            n_checks++;
            if (sto_valid !== 1'b1 || sto_data !== d[i]) begin
                n_fails++;
                $display("FAIL passthrough[%0d]: got v=%b d=%h, expected v=1 d=%h", i, sto_valid, sto_data, d[i]);
            end
        end
        cyc(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (sto_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL passthrough_idle: got v=%b, expected v=0", sto_valid);
        end
    endtask

    task automatic test_run8;
        logic [31:0] d  [6] = '{32'hFFFF_FF85, 32'h0000_0005, 32'h1234_5605, 32'h0000_0005, 32'h0000_0007, 32'h0};
        bit          vv [6] = '{1, 1, 1, 1, 1, 0};
        bit          ev [6] = '{1, 0, 0, 0, 1, 1};
        logic [31:0] ed [6] = '{32'h05, 32'h0, 32'h0, 32'h0, 32'h83, 32'h07};
        set_mode(4'b1110);
        for (int i = 0; i < 6; i++) begin
            cyc(vv[i], d[i], 1'b0);
            n_checks++;
            if (sto_valid !== ev[i] || (ev[i] && sto_data !== ed[i])) begin
                n_fails++;
                $display("FAIL run8[%0d]: got v=%b d=%h, expected v=%b d=%h", i, sto_valid, sto_data, ev[i], ed[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d  [6] = '{32'h0000_0011, 32'hABCD_8011, 32'h0000_0022, 32'h0000_0033, 32'h0, 32'h0};
        bit          vv [6] = '{1, 1, 1, 1, 0, 0};
        bit          fl [6] = '{0, 0, 0, 0, 0, 1};
        bit          ev [6] = '{1, 0, 1, 1, 1, 0};
        logic [31:0] ed [6] = '{32'h0011, 32'h0, 32'h8001, 32'h0022, 32'h0033, 32'h0};
        set_mode(4'b1100);
        for (int i = 0; i < 6; i++) begin
            cyc(vv[i], d[i], fl[i]);
            n_checks++;
            if (sto_valid !== ev[i] || (ev[i] && sto_data !== ed[i])) begin
                n_fails++;
                $display("FAIL back_to_back[%0d]: got v=%b d=%h, expected v=%b d=%h", i, sto_valid, sto_data, ev[i], ed[i]);
            end
        end
    endtask

    task automatic test_saturation;
        bit          ev;
        logic [31:0] ed;
        set_mode(4'b1110);
        for (int i = 1; i <= 130; i++) begin
            cyc(1'b1, ($urandom & 32'hFFFF_FF80) | 32'h10, i == 130);
            ev = (i == 1 || i == 129);
            ed = (i == 1) ? 32'h10 : 32'hFF;
            n_checks++;
            if (sto_valid !== ev || (ev && sto_data !== ed)) begin
                n_fails++;
                $display("FAIL saturation[%0d]: got v=%b d=%h, expected v=%b d=%h", i, sto_valid, sto_data, ev, ed);
            end
        end
        cyc(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (sto_valid !== 1'b1 || sto_data !== 32'h82) begin
            n_fails++;
            $display("FAIL saturation_tail: got v=%b d=%h, expected v=1 d=00000082", sto_valid, sto_data);
        end
        cyc(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (sto_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL saturation_idle: got v=%b, expected v=0", sto_valid);
        end
    endtask

    task automatic test_flush;
        logic [31:0] d  [7] = '{32'hFF80_0AAA, 32'h0000_0AAA, 32'h0000_0AAA, 32'h0, 32'h0000_0AAA, 32'h0, 32'h0};
        bit          vv [7] = '{1, 1, 1, 0, 1, 0, 0};
        bit          fl [7] = '{0, 0, 1, 0, 0, 1, 0};
        bit          ev [7] = '{1, 0, 0, 1, 1, 0, 0};
        logic [31:0] ed [7] = '{32'h000AAA, 32'h0, 32'h0, 32'h800002, 32'h000AAA, 32'h0, 32'h0};
        set_mode(4'b1000);
        // width stays frozen at 24 while encoding
        disabledGroups = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            cyc(vv[i], d[i], fl[i]);
            n_checks++;
            if (sto_valid !== ev[i] || (ev[i] && sto_data !== ed[i])) begin
                n_fails++;
                $display("FAIL flush[%0d]: got v=%b d=%h, expected v=%b d=%h", i, sto_valid, sto_data, ev[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset_midrun;
        set_mode(4'b1110);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h05, 1'b0);
        #2; rst_n = 1'b0; #1;
        n_checks++;
        if (sto_valid !== 1'b0 || sto_data !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_midrun: got v=%b d=%h, expected v=0 d=00000000", sto_valid, sto_data);
        end
        @(negedge clk); rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b1);
        n_checks++;
        if (sto_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_nocount: got v=%b d=%h, expected v=0", sto_valid, sto_data);
        end
        cyc(1'b1, 32'h05, 1'b0);
        n_checks++;
        if (sto_valid !== 1'b1 || sto_data !== 32'h05) begin
            n_fails++;
            $display("FAIL reset_value: got v=%b d=%h, expected v=1 d=00000005", sto_valid, sto_data);
        end
        cyc(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            logic [3:0]  dg;
            int          en, w, nruns, len, pick, i, L;
            longint      rem, nmax;
            logic [31:0] mask, flag, val, cur;
            logic [31:0] raw[$];
            logic [31:0] exp_q[$];
            logic [31:0] got[$];
            raw.delete(); exp_q.delete(); got.delete();
            dg   = 4'($urandom_range(0, 15));
            en   = 4 - $countones(dg);
            w    = (en == 0) ? 32 : en * 8;
            mask = (w == 32) ? 32'h7FFF_FFFF : ((32'd1 << (w - 1)) - 32'd1);
            flag = mask + 32'd1;
            nmax = longint'(mask);
            nruns = $urandom_range(4, 12);
            for (int r = 0; r < nruns; r++) begin
                pick = $urandom_range(0, 2);
                val  = (pick == 0) ? 32'h3 : (pick == 1) ? (32'h5A & mask) : mask;
                len  = (w == 8 && $urandom_range(0, 3) == 0) ? $urandom_range(120, 300) : $urandom_range(1, 5);
                for (int k = 0; k < len; k++) raw.push_back(val | ($urandom & ~mask));
            end
            // reference: group equal masked samples into runs, split at N_max
            i = 0;
            while (i < raw.size()) begin
                cur = raw[i] & mask;
                L = 1;
                while (i + L < raw.size() && (raw[i + L] & mask) == cur) L++;
                exp_q.push_back(cur);
                rem = L - 1;
                while (rem > nmax) begin
                    exp_q.push_back(flag | mask);
                    rem -= nmax;
                end
                if (rem > 0) exp_q.push_back(flag | 32'(rem));
                i += L;
            end
            set_mode(dg);
            foreach (raw[j]) begin
                if ($urandom_range(0, 3) == 0) begin
                    cyc(1'b0, $urandom, 1'b0);
                    if (sto_valid) got.push_back(sto_data);
                end
                cyc(1'b1, raw[j], 1'b0);
                if (sto_valid) got.push_back(sto_data);
            end
            cyc(1'b0, 32'h0, 1'b1);
            if (sto_valid) got.push_back(sto_data);
            for (int k = 0; k < 4; k++) begin
                cyc(1'b0, 32'h0, 1'b0);
                if (sto_valid) got.push_back(sto_data);
            end
            n_checks++;
            if (got.size() != exp_q.size()) begin
                n_fails++;
                $display("FAIL random[%0d] length: got %0d words, expected %0d (W=%0d)", it, got.size(), exp_q.size(), w);
            end
            for (int j = 0; j < got.size() && j < exp_q.size(); j++) begin
                n_checks++;
                if (got[j] !== exp_q[j]) begin
                    n_fails++;
                    $display("FAIL random[%0d] word %0d: got %h, expected %h (W=%0d)", it, j, got[j], exp_q[j], w);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_passthrough;
        test_run8;
        test_back_to_back;
        test_saturation;
        test_flush;
        test_reset_midrun;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
